// File: rtl/fpu_mul_exp_pkg.sv
// Shared definitions for the FP multiplier exponent pipe: special-operand
// class encoding and the signed internal width derivation.
package fpu_mul_exp_pkg;

  // Operand special class as presented on in_spec
  typedef enum logic [1:0] {
    SPEC_NORM = 2'd0,
    SPEC_ZERO = 2'd1,
    SPEC_INF  = 2'd2,
    SPEC_NAN  = 2'd3
  } spec_e;

  localparam int SPEC_W = 2;

  // Two extra bits hold the sum of two exponents and the sign after
  // subtracting the bias and the normalisation shift.
  function automatic int ext_w(input int exp_w);
    return exp_w + 2;
  endfunction

endpackage

// File: rtl/fpu_exp_rnd_clamp.sv
// Final-stage exponent resolution: applies the rounding carry, then
// classifies the result as underflow, overflow or in-range, and resolves
// special operand classes. Purely combinational; the caller registers it.
// Subnormal shift output is enabled by FPU_MUL_EXP_SUBNORM_EN.
module fpu_exp_rnd_clamp
  import fpu_mul_exp_pkg::*;
#(
  parameter int EXP_W = 11
) (
  input  logic                           vld,
  input  logic [SPEC_W-1:0]              spec,
  input  logic signed [ext_w(EXP_W)-1:0] s3,
  input  logic                           rnd_cout,
  input  logic                           rnd_to_inf,
  output logic [EXP_W-1:0]               res_exp,
  output logic                           res_of,
  output logic                           res_uf,
  output logic [ext_w(EXP_W)-1:0]        res_den
);

  localparam int EXT_W = ext_w(EXP_W);
  localparam logic signed [EXT_W-1:0] E_ZERO = '0;
  localparam logic signed [EXT_W-1:0] E_MAX  = EXT_W'((1 << EXP_W) - 1);
`ifdef FPU_MUL_EXP_SUBNORM_EN
  localparam logic signed [EXT_W-1:0] E_ONE  = EXT_W'(1);
`endif

  logic signed [EXT_W-1:0] e;

  // Overflow saturation: largest finite value unless rounding toward infinity
  function automatic logic [EXP_W-1:0] sat_exp(input logic to_inf);
    logic [EXP_W-1:0] ones;
    ones = '1;
    return to_inf ? ones : ones - EXP_W'(1);
  endfunction

  // Resolve the output exponent and exception flags for the current slot
  always_comb begin
    e       = s3 + $signed({{(EXT_W-1){1'b0}}, rnd_cout});
    res_exp = '0;
    res_of  = 1'b0;
    res_uf  = 1'b0;
    res_den = '0;
    if (vld) begin
      case (spec_e'(spec))
        SPEC_NORM: begin
          if (e <= E_ZERO) begin
            res_uf = 1'b1;
`ifdef FPU_MUL_EXP_SUBNORM_EN
            res_den = E_ONE - e;
`endif
          end else if (e >= E_MAX) begin
            res_of  = 1'b1;
            res_exp = sat_exp(rnd_to_inf);
          end else begin
            res_exp = e[EXP_W-1:0];
          end
        end
        SPEC_ZERO: res_exp = '0;
        SPEC_INF:  res_exp = '1;
        SPEC_NAN:  res_exp = '1;
        default:   res_exp = '0;
      endcase
    end
  end

endmodule

// File: rtl/fpu_mul_exp_pipe.sv
// Four-stage exponent pipe of a floating-point multiplier. Stages advance
// only when step is high; a synchronous active-low reset flushes all slots.
// Optional subnormal shift output: define FPU_MUL_EXP_SUBNORM_EN.
module fpu_mul_exp_pipe
  import fpu_mul_exp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int BIAS  = 1023,
  parameter int LZ_W  = 7
) (
  input  logic                    rclk,
  input  logic                    rst_l,
  input  logic                    step,
  input  logic                    in_vld,
  input  logic [EXP_W-1:0]        in_exp1,
  input  logic [EXP_W-1:0]        in_exp2,
  input  logic [1:0]              in_spec,
  input  logic [LZ_W-1:0]         s3_ld0,
  input  logic                    s4_rnd_cout,
  input  logic                    rnd_to_inf,
  output logic                    out_vld,
  output logic [EXP_W-1:0]        out_exp,
  output logic                    out_of,
  output logic                    out_uf,
  output logic [ext_w(EXP_W)-1:0] den_shift
);

  localparam int EXT_W = ext_w(EXP_W);
  localparam logic signed [EXT_W-1:0] BIAS_X = EXT_W'(BIAS);

  logic                    vld_p1, vld_p2, vld_p3;
  logic [1:0]              spec_p1, spec_p2, spec_p3;
  logic [EXP_W-1:0]        exp1_p1, exp2_p1;
  logic signed [EXT_W-1:0] sum_p2, s3_p3;

  logic [EXP_W-1:0]        c_exp;
  logic                    c_of, c_uf;
  logic [EXT_W-1:0]        c_den;

  // S1: capture operands and class
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      vld_p1  <= 1'b0;
      spec_p1 <= '0;
      exp1_p1 <= '0;
      exp2_p1 <= '0;
    end else if (step) begin
      vld_p1  <= in_vld;
      spec_p1 <= in_spec;
      exp1_p1 <= in_exp1;
      exp2_p1 <= in_exp2;
    end
  end

  // S2: biased exponent sum
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      vld_p2  <= 1'b0;
      spec_p2 <= '0;
      sum_p2  <= '0;
    end else if (step) begin
      vld_p2  <= vld_p1;
      spec_p2 <= spec_p1;
      sum_p2  <= $signed({2'b00, exp1_p1}) + $signed({2'b00, exp2_p1}) - BIAS_X;
    end
  end

  // S3: subtract normalisation shift
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      vld_p3  <= 1'b0;
      spec_p3 <= '0;
      s3_p3   <= '0;
    end else if (step) begin
      vld_p3  <= vld_p2;
      spec_p3 <= spec_p2;
      s3_p3   <= sum_p2 - $signed({{(EXT_W-LZ_W){1'b0}}, s3_ld0});
    end
  end

  fpu_exp_rnd_clamp #(
    .EXP_W(EXP_W)
  ) u_clamp (
    .vld       (vld_p3),
    .spec      (spec_p3),
    .s3        (s3_p3),
    .rnd_cout  (s4_rnd_cout),
    .rnd_to_inf(rnd_to_inf),
    .res_exp   (c_exp),
    .res_of    (c_of),
    .res_uf    (c_uf),
    .res_den   (c_den)
  );

  // S4: register rounded, clamped result onto the outputs
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      out_vld   <= 1'b0;
      out_exp   <= '0;
      out_of    <= 1'b0;
      out_uf    <= 1'b0;
      den_shift <= '0;
    end else if (step) begin
      out_vld   <= vld_p3;
      out_exp   <= c_exp;
      out_of    <= c_of;
      out_uf    <= c_uf;
      den_shift <= c_den;
    end
  end

endmodule

// File: tb/tb_fpu_mul_exp_pipe.sv
// Scoreboard bench for fpu_mul_exp_pipe: directed corner cases followed by
// randomized traffic with stalls and a mid-stream reset.
module tb_fpu_mul_exp_pipe;

  localparam int EXP_W = 11;
  localparam int BIAS  = 1023;
  localparam int LZ_W  = 7;
  localparam int EXT_W = EXP_W + 2;
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             step = 1'b0;
  logic             in_vld = 1'b0;
  logic [EXP_W-1:0] in_exp1 = '0;
  logic [EXP_W-1:0] in_exp2 = '0;
  logic [1:0]       in_spec = '0;
  logic [LZ_W-1:0]  s3_ld0 = '0;
  logic             s4_rnd_cout = 1'b0;
  logic             rnd_to_inf = 1'b0;
  logic             out_vld;
  logic [EXP_W-1:0] out_exp;
  logic             out_of;
  logic             out_uf;
  logic [EXT_W-1:0] den_shift;

  fpu_mul_exp_pipe #(.EXP_W(EXP_W), .BIAS(BIAS), .LZ_W(LZ_W)) dut (
    .rclk       (clk),
    .rst_l      (rst_l),
    .step       (step),
    .in_vld     (in_vld),
    .in_exp1    (in_exp1),
    .in_exp2    (in_exp2),
    .in_spec    (in_spec),
    .s3_ld0     (s3_ld0),
    .s4_rnd_cout(s4_rnd_cout),
    .rnd_to_inf (rnd_to_inf),
    .out_vld    (out_vld),
    .out_exp    (out_exp),
    .out_of     (out_of),
    .out_uf     (out_uf),
    .den_shift  (den_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vld;
    int e1;
    int e2;
    int spec;
    int ld0;
    bit cout;
    bit rti;
  } txn_t;

  typedef struct {
    int ex;
    bit of;
    bit uf;
    int den;
  } rsp_t;

  rsp_t expq[$];
  txn_t sl[1:4];
  int   checks = 0;
  int   errors = 0;

  // Reference: the exponent rules evaluated with plain integer arithmetic
  function automatic rsp_t model(input txn_t t);
    rsp_t r;
    int   e;
    r = '{ex: 0, of: 1'b0, uf: 1'b0, den: 0};
    if (t.spec == 1) r.ex = 0;
    else if (t.spec >= 2) r.ex = EMAX;
    else begin
      e = t.e1 + t.e2 - BIAS - t.ld0 + int'(t.cout);
      if (e <= 0) begin
        r.uf = 1'b1;
`ifdef FPU_MUL_EXP_SUBNORM_EN
        r.den = 1 - e;
`endif
      end else if (e >= EMAX) begin
        r.of = 1'b1;
        r.ex = t.rti ? EMAX : EMAX - 1;
      end else begin
        r.ex = e;
      end
    end
    return r;
  endfunction

  function automatic txn_t mk(input int e1, input int e2, input int spec,
                              input int ld0, input bit cout, input bit rti);
    txn_t t;
    t = '{vld: 1'b1, e1: e1, e2: e2, spec: spec, ld0: ld0, cout: cout, rti: rti};
    return t;
  endfunction

  function automatic txn_t bubble();
    txn_t t;
    t = '{vld: 1'b0, e1: 0, e2: 0, spec: 0, ld0: 0, cout: 1'b0, rti: 1'b0};
    return t;
  endfunction

  // One clock edge; late-stage inputs follow the op that sits in the stage they feed
  task automatic do_edge(input txn_t t, input bit stp);
    step        = stp;
    in_vld      = t.vld;
    in_exp1     = EXP_W'(t.e1);
    in_exp2     = EXP_W'(t.e2);
    in_spec     = 2'(t.spec);
    s3_ld0      = LZ_W'(sl[2].ld0);
    s4_rnd_cout = sl[3].cout;
    rnd_to_inf  = sl[3].rti;
    @(posedge clk);
    #1;
    if (stp) begin
      sl[4] = sl[3];
      sl[3] = sl[2];
      sl[2] = sl[1];
      sl[1] = t;
      if (t.vld) expq.push_back(model(t));
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) do_edge(bubble(), 1'b1);
  endtask

  task automatic do_reset();
    rst_l  = 1'b0;
    step   = 1'($urandom_range(0, 1));
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    for (int k = 1; k <= 4; k++) sl[k] = bubble();
    expq.delete();
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    int   mode;
    t = bubble();
    t.vld = ($urandom_range(0, 3) != 0);
    mode = $urandom_range(0, 2);
    if (mode == 0) begin
      t.e1 = $urandom_range(0, EMAX);
      t.e2 = $urandom_range(0, EMAX);
    end else if (mode == 1) begin
      t.e1 = $urandom_range(900, 1150);
      t.e2 = $urandom_range(0, 200);
    end else begin
      t.e1 = $urandom_range(1500, EMAX);
      t.e2 = $urandom_range(1400, EMAX);
    end
    t.spec = ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 3);
    t.ld0  = $urandom_range(0, (1 << LZ_W) - 1);
    t.cout = 1'($urandom_range(0, 1));
    t.rti  = 1'($urandom_range(0, 1));
    return t;
  endfunction

  // Edge bookkeeping for the monitor
  bit edge_step = 1'b0;
  bit edge_rst  = 1'b0;
  logic [EXT_W+EXP_W+2:0] prev_bus = '0;
  logic [EXT_W+EXP_W+2:0] cur_bus;
  assign cur_bus = {out_vld, out_exp, out_of, out_uf, den_shift};

  always @(posedge clk) begin
    edge_step <= step;
    edge_rst  <= !rst_l;
  end

  // Monitor: compare each newly presented result against the scoreboard
  always @(negedge clk) begin
    rsp_t exp_r;
    if (edge_rst) begin
      checks++;
      if (cur_bus != '0) begin
        errors++;
        $display("FAIL reset_clear got=%h required=0", cur_bus);
      end
    end else if (!edge_step) begin
      checks++;
      if (cur_bus !== prev_bus) begin
        errors++;
        $display("FAIL stall_hold got=%h required=%h", cur_bus, prev_bus);
      end
    end else if (out_vld) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got exp=%0d of=%0d uf=%0d den=%0d required no valid",
                 out_exp, out_of, out_uf, den_shift);
      end else begin
        exp_r = expq.pop_front();
        if (int'(out_exp) != exp_r.ex || out_of != exp_r.of || out_uf != exp_r.uf ||
            int'(den_shift) != exp_r.den) begin
          errors++;
          $display("FAIL result got exp=%0d of=%0d uf=%0d den=%0d required exp=%0d of=%0d uf=%0d den=%0d",
                   out_exp, out_of, out_uf, den_shift, exp_r.ex, exp_r.of, exp_r.uf, exp_r.den);
        end
      end
    end else begin
      checks++;
      if (out_of || out_uf || den_shift != '0) begin
        errors++;
        $display("FAIL bubble_flags got of=%0d uf=%0d den=%0d required 0 0 0",
                 out_of, out_uf, den_shift);
      end
    end
    prev_bus <= cur_bus;
  end

  initial begin
    for (int k = 1; k <= 4; k++) sl[k] = bubble();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Nominal, carry, overflow saturation, underflow threshold, specials
    do_edge(mk(1023, 1023, 0, 0, 1'b0, 1'b0), 1'b1);
    do_edge(mk(1023, 1023, 0, 0, 1'b1, 1'b0), 1'b1);
    do_edge(mk(1800, 1800, 0, 0, 1'b0, 1'b1), 1'b1);
    do_edge(mk(1800, 1800, 0, 0, 1'b0, 1'b0), 1'b1);
    do_edge(mk(600, 500, 0, 76, 1'b0, 1'b0), 1'b1);
    do_edge(mk(600, 500, 0, 77, 1'b0, 1'b0), 1'b1);
    do_edge(mk(100, 100, 3, 0, 1'b0, 1'b0), 1'b1);
    do_edge(mk(100, 100, 1, 0, 1'b0, 1'b0), 1'b1);
    flush(5);

    // A, B, stall three cycles, then C
    do_edge(mk(1100, 1000, 0, 3, 1'b1, 1'b0), 1'b1);
    do_edge(mk(1200, 900, 0, 10, 1'b0, 1'b0), 1'b1);
    repeat (3) do_edge(mk(5, 5, 0, 0, 1'b0, 1'b0), 1'b0);
    do_edge(mk(1300, 800, 2, 0, 1'b0, 1'b0), 1'b1);
    flush(5);

    // Reset with three ops in flight, then idle
    do_edge(mk(1023, 1030, 0, 1, 1'b0, 1'b0), 1'b1);
    do_edge(mk(1040, 1023, 0, 2, 1'b0, 1'b0), 1'b1);
    do_edge(mk(1050, 1023, 0, 3, 1'b0, 1'b0), 1'b1);
    do_reset();
    flush(6);

    // Randomized traffic with stalls and one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      do_edge(rnd_txn(), ($urandom_range(0, 3) != 0));
    end
    flush(6);

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d results outstanding required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
